data_brk: RTL

Data-break (DMA) arbiter and sequencer for the PDP-8/E core. Collects single-cycle data-break requests from up to `N_REQ` peripherals, asks the CPU major-state sequencer for a break cycle, and resolves priority at the grant point. It then runs a fixed four-phase memory cycle (B0–B3) on the full 15-bit extended address (field + 12-bit address). Supported transfers are read, write, or memory-increment (MI), and the result and handshake are returned to the winning device.

---
 rtl/data_brk.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/data_brk.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : data_brk                                                 |
// | Purpose : PDP-8/E data-break arbiter and B0-B3 memory sequencer    |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module data_brk #(
  parameter int N_REQ = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*15-1:0] dev_addr,
  input  logic [N_REQ*12-1:0] dev_wdata,
  input  logic [N_REQ-1:0]    dev_wr,
  input  logic [N_REQ-1:0]    dev_inc,
  input  logic                brk_go,
  input  logic [0:11]         mdout,
  output logic                brk_req,
  output logic                brk_active,
  output logic [0:14]         mem_addr,
  output logic [0:11]         mem_wdata,
  output logic                mem_we,
  output logic [N_REQ-1:0]    dev_ack,
  output logic [0:11]         brk_data,
  output logic                brk_ovf
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_B0   = 3'd2,
    ST_B1   = 3'd3,
    ST_B2   = 3'd4,
    ST_B3   = 3'd5
  } state_t;

  localparam logic [11:0] c_WORD_MAX = 12'o7777;

  state_t             r_state,      w_state_nxt;
  logic               r_brk_req,    w_brk_req_nxt;
  logic               r_brk_active, w_brk_active_nxt;
  logic [14:0]        r_mem_addr,   w_mem_addr_nxt;
  logic [11:0]        r_mem_wdata,  w_mem_wdata_nxt;
  logic               r_mem_we,     w_mem_we_nxt;
  logic [N_REQ-1:0]   r_dev_ack,    w_dev_ack_nxt;
  logic [11:0]        r_brk_data,   w_brk_data_nxt;
  logic               r_brk_ovf,    w_brk_ovf_nxt;
  logic [N_REQ-1:0]   r_win_oh,     w_win_oh_nxt;
  logic [11:0]        r_wdata,      w_wdata_nxt;
  logic               r_wr,         w_wr_nxt;
  logic               r_inc,        w_inc_nxt;
  logic               r_clr_pend,   w_clr_pend_nxt;
  logic               w_init;

  logic [N_REQ-1:0]   w_sel_oh;
  logic [14:0]        w_sel_addr;
  logic [11:0]        w_sel_wdata;
  logic               w_sel_wr;
  logic               w_sel_inc;
  logic [11:0]        w_rd;
  logic [11:0]        w_inc_word;

  // Scan from the lowest priority upward so the lowest set index wins.
  always_comb begin
    w_sel_oh    = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wr    = 1'b0;
    w_sel_inc   = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_sel_oh    = '0;
        w_sel_oh[i] = 1'b1;
        w_sel_addr  = dev_addr[i*15 +: 15];
        w_sel_wdata = dev_wdata[i*12 +: 12];
        w_sel_wr    = dev_wr[i];
        w_sel_inc   = dev_inc[i];
      end
    end
  end

  assign w_rd       = mdout;
  assign w_inc_word = w_rd + 12'd1;

  always_comb begin
    w_state_nxt      = r_state;
    w_brk_req_nxt    = r_brk_req;
    w_brk_active_nxt = r_brk_active;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_mem_we_nxt     = 1'b0;
    w_dev_ack_nxt    = '0;
    w_brk_data_nxt   = r_brk_data;
    w_brk_ovf_nxt    = r_brk_ovf;
    w_win_oh_nxt     = r_win_oh;
    w_wdata_nxt      = r_wdata;
    w_wr_nxt         = r_wr;
    w_inc_nxt        = r_inc;
    w_clr_pend_nxt   = r_clr_pend;
    w_init           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (clear) begin
          w_init = 1'b1;
        end else if (|req) begin
          w_state_nxt   = ST_REQ;
          w_brk_req_nxt = 1'b1;
        end
      end

      ST_REQ: begin
        if (clear) begin
          w_init = 1'b1;
        end else if (req == '0) begin
          w_state_nxt   = ST_IDLE;
          w_brk_req_nxt = 1'b0;
        end else if (brk_go) begin
          w_state_nxt      = ST_B0;
          w_brk_req_nxt    = 1'b0;
          w_brk_active_nxt = 1'b1;
          w_mem_addr_nxt   = w_sel_addr;
          w_win_oh_nxt     = w_sel_oh;
          w_wdata_nxt      = w_sel_wdata;
          w_wr_nxt         = w_sel_wr;
          w_inc_nxt        = w_sel_inc;
          w_clr_pend_nxt   = 1'b0;
        end
      end

      ST_B0: begin
        w_state_nxt    = ST_B1;
        w_clr_pend_nxt = r_clr_pend | clear;
      end

      // Memory data is settled by now; form the result and the write word.
      ST_B1: begin
        w_state_nxt    = ST_B2;
        w_clr_pend_nxt = r_clr_pend | clear;
        w_mem_we_nxt   = r_inc | r_wr;
        if (r_inc) begin
          w_mem_wdata_nxt = w_inc_word;
          w_brk_data_nxt  = w_inc_word;
          w_brk_ovf_nxt   = (w_rd == c_WORD_MAX);
        end else begin
          w_brk_data_nxt = w_rd;
          w_brk_ovf_nxt  = 1'b0;
          if (r_wr) begin
            w_mem_wdata_nxt = r_wdata;
          end
        end
      end

      ST_B2: begin
        w_state_nxt    = ST_B3;
        w_clr_pend_nxt = r_clr_pend | clear;
        w_dev_ack_nxt  = r_win_oh;
      end

      // The winner's own request is ignored here: it is still high while it sees its ack.
      ST_B3: begin
        w_brk_active_nxt = 1'b0;
        w_clr_pend_nxt   = 1'b0;
        if (!(r_clr_pend || clear) && (|(req & ~r_win_oh))) begin
          w_state_nxt   = ST_REQ;
          w_brk_req_nxt = 1'b1;
        end else begin
          w_state_nxt   = ST_IDLE;
          w_brk_req_nxt = 1'b0;
        end
      end

      default: begin
        w_init = 1'b1;
      end
    endcase

    if (w_init) begin
      w_state_nxt      = ST_IDLE;
      w_brk_req_nxt    = 1'b0;
      w_brk_active_nxt = 1'b0;
      w_mem_addr_nxt   = '0;
      w_mem_wdata_nxt  = '0;
      w_mem_we_nxt     = 1'b0;
      w_dev_ack_nxt    = '0;
      w_brk_data_nxt   = '0;
      w_brk_ovf_nxt    = 1'b0;
      w_win_oh_nxt     = '0;
      w_wdata_nxt      = '0;
      w_wr_nxt         = 1'b0;
      w_inc_nxt        = 1'b0;
      w_clr_pend_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_brk_req    <= 1'b0;
      r_brk_active <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
      r_dev_ack    <= '0;
      r_brk_data   <= '0;
      r_brk_ovf    <= 1'b0;
      r_win_oh     <= '0;
      r_wdata      <= '0;
      r_wr         <= 1'b0;
      r_inc        <= 1'b0;
      r_clr_pend   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_brk_req    <= w_brk_req_nxt;
      r_brk_active <= w_brk_active_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_dev_ack    <= w_dev_ack_nxt;
      r_brk_data   <= w_brk_data_nxt;
      r_brk_ovf    <= w_brk_ovf_nxt;
      r_win_oh     <= w_win_oh_nxt;
      r_wdata      <= w_wdata_nxt;
      r_wr         <= w_wr_nxt;
      r_inc        <= w_inc_nxt;
      r_clr_pend   <= w_clr_pend_nxt;
    end
  end

  assign brk_req    = r_brk_req;
  assign brk_active = r_brk_active;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_we     = r_mem_we;
  assign dev_ack    = r_dev_ack;
  assign brk_data   = r_brk_data;
  assign brk_ovf    = r_brk_ovf;

endmodule
`default_nettype wire
